// File: rtl/popcount_expander.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_expander
//  Description : Expands a 6-bit count (0..32, clamped above 32) into a
//                32-bit thermometer vector whose popcount equals the count.
//                Fully pipelined, fixed latency, valid/ready on both sides,
//                with a saturating counter of clamped inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_expander #(
    parameter int PIPE_STAGES = 3,
    parameter int SAT_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           in_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_vec,
    output logic                 out_sat,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int c_last_stage = PIPE_STAGES - 1;

    // Reject unsupported pipeline depths at elaboration time
    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_pipe_stages
            $error("popcount_expander: PIPE_STAGES must be within 1..8");
        end
    endgenerate

    logic [PIPE_STAGES-1:0] r_valid;
    logic [31:0]            r_vec [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] r_sat;
    logic [SAT_CNT_W-1:0]   r_sat_count;

    logic [PIPE_STAGES-1:0] w_load;
    logic                   w_chain;
    logic                   w_in_sat;
    logic [5:0]             w_n;
    logic [31:0]            w_in_vec;
    logic                   w_accept;

    // Decode the incoming count into a clamped thermometer vector
    always_comb begin
        w_in_sat = (in_count > 6'd32);
        w_n      = w_in_sat ? 6'd32 : in_count;
        w_in_vec = '0;
        for (int i = 0; i < 32; i++) begin
            w_in_vec[i] = (i < int'(w_n));
        end
    end

    // Load enables, rippling back from the output: a stage may load when it is
    // empty or when its contents move on this cycle (the next stage loads, or
    // for the last stage, downstream pops it). A bubble therefore collapses.
    always_comb begin
        w_load  = '0;
        w_chain = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            w_load[k] = ~r_valid[k] | w_chain;
            w_chain   = w_load[k];
        end
    end

    assign in_ready = w_load[0];
    assign w_accept = in_valid & w_load[0];

    // Pipeline registers; data only captured when the source holds a valid item
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_sat   <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_vec[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_vec[0] <= w_in_vec;
                    r_sat[0] <= w_in_sat;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_vec[k] <= r_vec[k-1];
                        r_sat[k] <= r_sat[k-1];
                    end
                end
            end
        end
    end

    // Count clamped inputs at accept time, holding at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (w_accept && w_in_sat && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign out_valid = r_valid[c_last_stage];
    assign out_vec   = r_vec[c_last_stage];
    assign out_sat   = r_sat[c_last_stage];
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_popcount_expander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount_expander
//  Description : Self-checking bench for popcount_expander using a queue
//                scoreboard and an arithmetic reference of the decode rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_expander;

    localparam int P = 3;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_count;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_vec;
    logic          out_sat;
    logic [SW-1:0] sat_count;

    popcount_expander #(.PIPE_STAGES(P), .SAT_CNT_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit sat;
        int acc;
    } item_t;

    item_t       q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          sat_model  = 0;
    bit          lat_on     = 1'b0;
    bit          last_acc   = 1'b0;
    bit          hold_prev  = 1'b0;
    logic [31:0] prev_vec   = '0;
    logic        prev_sat   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Thermometer reference: the lowest n bits set, as 2^n - 1
    function automatic logic [31:0] thermo(input int n);
        longint v;
        v = (longint'(1) << n) - 1;
        return v[31:0];
    endfunction

    // One clock cycle: score the handshakes seen before the edge, then advance
    task automatic cycle();
        item_t e;
        int    c;
        #1;
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            sat_model = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_vec", out_vec, prev_vec);
                chk("hold_sat", out_sat, prev_sat);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_vec", out_vec, thermo(e.n));
                    chk("out_sat", out_sat, e.sat);
                    chk("popcount", $countones(out_vec), e.n);
                    if (lat_on) chk("latency", cyc - e.acc, P);
                end
            end
            if (in_valid && in_ready) begin
                c = int'(in_count);
                e.n   = (c > 32) ? 32 : c;
                e.sat = (c > 32);
                e.acc = cyc;
                q.push_back(e);
                if (c > 32 && sat_model < (1 << SW) - 1) sat_model++;
                last_acc = 1'b1;
            end
            hold_prev = out_valid && !out_ready;
            prev_vec  = out_vec;
            prev_sat  = out_sat;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("sat_count", sat_count, sat_model);
    endtask

    task automatic push_one(input logic [5:0] c);
        int guard;
        in_valid = 1'b1;
        in_count = c;
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!last_acc && guard < 200);
        if (!last_acc) chk("push_timeout", last_acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 500) begin
            cycle();
            guard++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [5:0] vals [10];
        int idx;
        int guard;
        int naccept;

        rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Test 1: boundary counts streamed back-to-back, fixed latency
        out_ready = 1'b1;
        lat_on = 1'b1;
        push_one(6'd0);
        push_one(6'd1);
        push_one(6'd5);
        push_one(6'd31);
        push_one(6'd32);
        drain();
        lat_on = 1'b0;

        // Test 2: clamped counts
        push_one(6'd33);
        push_one(6'd63);
        drain();
        chk("sat_after_two", sat_count, 2);

        // Test 3: backpressure fills exactly P stages, then drains in order
        for (int i = 0; i < 10; i++) vals[i] = 6'($urandom_range(0, 63));
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_count = vals[idx];
            cycle();
            if (last_acc) idx++;
        end
        chk("bp_accepts", idx, P);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        while (idx < 10) begin
            push_one(vals[idx]);
            idx++;
        end
        drain();

        // Test 4: 1000 random counts under random backpressure
        naccept = 0;
        guard = 0;
        while (naccept < 1000 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_count  = 6'($urandom_range(0, 63));
            out_ready = $urandom_range(0, 1) == 1;
            cycle();
            if (last_acc) naccept++;
            guard++;
        end
        chk("rand_accepts", naccept, 1000);
        drain();

        // Test 5: reset with the pipeline partially filled
        out_ready = 1'b0;
        push_one(6'd50);
        push_one(6'd7);
        chk("pre_rst_valid", out_valid, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_count = 6'd45;
        cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_sat", sat_count, 0);
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * P + 4; i++) begin
            cycle();
            chk("no_stale_out", out_valid, 0);
        end

        // Test 6: saturation of the clamp counter
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) push_one(6'd40);
        drain();
        chk("sat_final", sat_count, 255);
        for (int i = 0; i < 3; i++) cycle();
        chk("sat_hold", sat_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/popcount_expander.md
Name: popcount_expander

Overview:
- Inverse of the team's 32-input population counter: takes a 6-bit count and regenerates a 32-bit thermometer vector whose popcount equals that count.
- Fully pipelined, with a valid/ready handshake on both sides.
- Used to build stimulus and balanced-fanout vectors upstream of the counter, and to close counter→expander loopback checks.
- Latency is fixed and set by parameter, matching the team's path-balanced style: every bit leaves the same stage.

Parameters:
- PIPE_STAGES, 3, number of register stages from accept to output (legal 1..8).
- SAT_CNT_W, 8, width of the saturation event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active high.
- in_valid  input  1  upstream has a count.
- in_ready  output  1  block accepts the count this cycle.
- in_count  input  6  count; legal range 0..32.
- out_valid  output  1  out_vec/out_sat hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_vec  output  32  thermometer result: bits [n-1:0] = 1, all other bits = 0.
- out_sat  output  1  the input for this result was >32 and was clamped.
- sat_count  output  SAT_CNT_W  saturating count of clamped inputs accepted since reset.

Behaviour:
- Reset (rst=1 at an edge): every stage's valid clears.
  - out_valid=0, out_vec=0, out_sat=0, sat_count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight data; no partial results are emitted.
- Handshake:
  - A transfer happens when valid & ready on a cycle edge.
  - in_ready and out_valid never depend combinationally on in_valid.
  - in_ready may depend combinationally on out_ready.
  - While out_valid=1 and out_ready=0, out_vec and out_sat hold stable.
- Decode:
  - n = min(in_count, 32); out_sat = (in_count > 32).
  - out_vec[i] = (i < n) for i = 0..31.
  - in_count = 0 gives out_vec = 0. in_count = 32..63 gives out_vec = 0xFFFFFFFF; out_sat is set for 33..63.
- Pipeline:
  - PIPE_STAGES registers, each with its own valid bit. Bubbles collapse.
  - Stage k loads from stage k-1 when stage k is empty or stage k is advancing this cycle.
  - The last stage advances on out_ready.
  - in_ready = (stage 1 empty) | (stage 1 advancing).
  - Latency: a count accepted at edge t is presented with out_valid=1 after edge t+PIPE_STAGES-1 when there is no backpressure.
  - Throughput is 1 per cycle when out_ready is held at 1.
  - Order is preserved; no result is dropped or duplicated under any out_ready pattern.
  - When the pipeline is full and out_ready=0, in_ready=0.
  - Simultaneous pop and push when full: both occur in the same cycle.
- sat_count:
  - Increments by 1 on each accepted input with in_count > 32.
  - Holds at 2^SAT_CNT_W-1 and does not wrap.
  - Increments at accept time, not at output time.
- Illegal PIPE_STAGES (outside 1..8) is an elaboration error.

Test Plan:
1. Reset, then stream in_count = 0,1,5,31,32 with out_ready=1 -> after PIPE_STAGES-cycle latency, out_vec = 0x00000000, 0x00000001, 0x0000001F, 0x7FFFFFFF, 0xFFFFFFFF on consecutive cycles; out_sat=0 throughout.
2. in_count = 33 then 63 -> out_vec = 0xFFFFFFFF both times, out_sat=1 both times, sat_count=2.
3. Hold out_ready=0 while feeding 10 counts -> exactly PIPE_STAGES are accepted, then in_ready=0. out_vec stays stable. Releasing out_ready drains all results in order with none lost.
4. Random out_ready (50% duty) with 1000 random counts 0..63 -> scoreboard matches: popcount(out_vec) = min(count, 32), in order; sat_count = min(#>32, 255).
5. Assert rst for 1 cycle with the pipeline half full -> next cycle out_valid=0, sat_count=0, in_ready=1; no stale result ever appears.
6. 300 consecutive in_count = 40 accepts -> sat_count saturates at 255 and stays there.
